// File: rtl/pio_switch_poller.sv
// pio_switch_poller
//   Periodically reads a 4-bit switch PIO, debounces the samples and exposes
//   the debounced state, an edge-capture register and a level interrupt to a
//   CPU through a small register slave.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   m_address    switch-PIO address (constant 0)
//   m_read       one-cycle read strobe to the switch PIO
//   m_readdata   PIO read data, valid the cycle after m_read; bits [3:0] used
//   s_address    CPU register select
//                  0 debounced state [3:0] (RO)
//                  1 control: bit0 enable, bit1 irq_en
//                  2 poll period [15:0]
//                  3 edge capture [3:0] (write 1 to clear)
//   s_read       CPU read strobe
//   s_write      CPU write strobe
//   s_writedata  CPU write data
//   s_readdata   registered read data, one cycle after s_read
//   irq          level interrupt: irq_en && any edge captured (registered)
module pio_switch_poller #(
    parameter int unsigned DEBOUNCE_COUNT = 4,
    parameter logic [15:0] PERIOD_DEFAULT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_UPDATE  = 2'd3;

    localparam logic [1:0] REG_STATE  = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_EDGE   = 2'd3;

    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_COUNT);

    logic [1:0]  state_q,       state_d;
    logic [15:0] cnt_q,         cnt_d;
    logic [15:0] period_q,      period_d;
    logic        enable_q,      enable_d;
    logic        irq_en_q,      irq_en_d;
    logic [3:0]  sample_q,      sample_d;
    logic [3:0]  last_sample_q, last_sample_d;
    logic [3:0]  stable_cnt_q,  stable_cnt_d;
    logic [3:0]  debounced_q,   debounced_d;
    logic [3:0]  edge_q,        edge_d;
    logic        irq_q,         irq_d;
    logic [31:0] rdata_q,       rdata_d;

    logic [3:0]  edge_set;
    logic [3:0]  edge_clr;

    // Bits of the data buses that carry nothing for this block.
    logic unused_bits;
    assign unused_bits = ^{m_readdata[31:4], s_writedata[31:16]};

    // A programmed period of 0 behaves as 1 so polling never stalls.
    function automatic logic [15:0] period_eff(input logic [15:0] p);
        return (p == '0) ? 16'd1 : p;
    endfunction

    assign m_address  = '0;
    assign m_read     = (state_q == ST_READ);
    assign s_readdata = rdata_q;
    assign irq        = irq_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        enable_d      = enable_q;
        irq_en_d      = irq_en_q;
        sample_d      = sample_q;
        last_sample_d = last_sample_q;
        stable_cnt_d  = stable_cnt_q;
        debounced_d   = debounced_q;
        rdata_d       = rdata_q;
        edge_set      = '0;
        edge_clr      = '0;

        // Read data is captured from the current register contents, so a
        // write in the same cycle is not yet visible.
        if (s_read) begin
            case (s_address)
                REG_STATE:  rdata_d = {28'd0, debounced_q};
                REG_CTRL:   rdata_d = {30'd0, irq_en_q, enable_q};
                REG_PERIOD: rdata_d = {16'd0, period_q};
                default:    rdata_d = {28'd0, edge_q};
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    // Counting down from N gives exactly N idle cycles.
                    if (cnt_q <= 16'd1) begin
                        state_d = ST_READ;
                        cnt_d   = period_eff(period_q);
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end else begin
                    cnt_d = period_eff(period_q);
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                sample_d = m_readdata[3:0];
                state_d  = ST_UPDATE;
            end
            default: begin
                if (sample_q == last_sample_q) begin
                    stable_cnt_d = (stable_cnt_q >= DEB_MAX) ? DEB_MAX
                                                             : stable_cnt_q + 4'd1;
                end else begin
                    stable_cnt_d = 4'd1;
                end
                last_sample_d = sample_q;
                if ((stable_cnt_d == DEB_MAX) && (sample_q != debounced_q)) begin
                    debounced_d = sample_q;
                    edge_set    = sample_q ^ debounced_q;
                end
                state_d = ST_IDLE;
            end
        endcase

        // CPU writes come last so a period write overrides any reload above.
        if (s_write) begin
            case (s_address)
                REG_CTRL: begin
                    enable_d = s_writedata[0];
                    irq_en_d = s_writedata[1];
                end
                REG_PERIOD: begin
                    period_d = s_writedata[15:0];
                    cnt_d    = period_eff(s_writedata[15:0]);
                end
                REG_EDGE: edge_clr = s_writedata[3:0];
                default: ;
            endcase
        end

        // A newly detected edge wins over a simultaneous clear.
        edge_d = (edge_q & ~edge_clr) | edge_set;
        irq_d  = irq_en_q & (|edge_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= PERIOD_DEFAULT;
            period_q      <= PERIOD_DEFAULT;
            enable_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            sample_q      <= '0;
            last_sample_q <= '0;
            stable_cnt_q  <= '0;
            debounced_q   <= '0;
            edge_q        <= '0;
            irq_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            enable_q      <= enable_d;
            irq_en_q      <= irq_en_d;
            sample_q      <= sample_d;
            last_sample_q <= last_sample_d;
            stable_cnt_q  <= stable_cnt_d;
            debounced_q   <= debounced_d;
            edge_q        <= edge_d;
            irq_q         <= irq_d;
            rdata_q       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pio_switch_poller.sv
`timescale 1ns/1ps
module tb_pio_switch_poller;

    localparam int unsigned DEB  = 4;
    localparam logic [15:0] PDEF = 16'd1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata = '0;
    logic [1:0]  s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic        irq;

    always #5 clk = ~clk;

    pio_switch_poller #(
        .DEBOUNCE_COUNT(DEB),
        .PERIOD_DEFAULT(PDEF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m_address  (m_address),
        .m_read     (m_read),
        .m_readdata (m_readdata),
        .s_address  (s_address),
        .s_read     (s_read),
        .s_write    (s_write),
        .s_writedata(s_writedata),
        .s_readdata (s_readdata),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [3:0] sw = '0;
    logic       pio_pending = 1'b0;

    // Reference model: phase 0 idle, 1 read strobe, 2 capture, 3 update.
    int          m_phase;
    int          m_idle_left;
    logic [3:0]  m_sample;
    logic [3:0]  hist[$];
    logic [3:0]  m_deb, m_edge;
    logic        m_irq, m_en, m_irqen;
    logic [15:0] m_period;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int eff(input logic [15:0] p);
        return (p == 16'd0) ? 1 : int'(p);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_idle_left = int'(PDEF); m_sample = '0;
        hist.delete();
        m_deb = '0; m_edge = '0; m_irq = 0; m_en = 0; m_irqen = 0;
        m_period = PDEF; m_rdata = '0;
    endtask

    task automatic model_step(input logic [1:0] sa, input logic srd, input logic swr,
                              input logic [31:0] swd, input logic [31:0] rd);
        logic [31:0] nrdata;
        logic        nirq;
        logic [3:0]  set, clr;
        bit          all_eq;
        nrdata = m_rdata;
        if (srd) begin
            case (sa)
                2'd0:    nrdata = {28'd0, m_deb};
                2'd1:    nrdata = {30'd0, m_irqen, m_en};
                2'd2:    nrdata = {16'd0, m_period};
                default: nrdata = {28'd0, m_edge};
            endcase
        end
        nirq = m_irqen && (m_edge != 4'd0);
        set = '0; clr = '0;
        case (m_phase)
            0: begin
                if (!m_en) m_idle_left = eff(m_period);
                else if (m_idle_left <= 1) begin m_phase = 1; m_idle_left = eff(m_period); end
                else m_idle_left--;
            end
            1: m_phase = 2;
            2: begin m_sample = rd[3:0]; m_phase = 3; end
            default: begin
                // Debounced value follows once the last DEB samples agree.
                hist.push_back(m_sample);
                if (hist.size() > int'(DEB)) void'(hist.pop_front());
                all_eq = (hist.size() == int'(DEB));
                foreach (hist[i]) if (hist[i] != m_sample) all_eq = 0;
                if (all_eq && (m_sample != m_deb)) begin
                    set = m_sample ^ m_deb;
                    m_deb = m_sample;
                end
                m_phase = 0;
            end
        endcase
        if (swr) begin
            case (sa)
                2'd1: begin m_en = swd[0]; m_irqen = swd[1]; end
                2'd2: begin m_period = swd[15:0]; m_idle_left = eff(swd[15:0]); end
                2'd3: clr = swd[3:0];
                default: ;
            endcase
        end
        m_edge  = (m_edge & ~clr) | set;
        m_irq   = nirq;
        m_rdata = nrdata;
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check
    // the outputs at the next falling edge. The PIO answers the strobe seen
    // on the previous cycle, with random junk otherwise.
    task automatic cycle(input logic [1:0] sa, input logic srd, input logic swr,
                         input logic [31:0] swd);
        logic [31:0] junk, rd;
        junk = $urandom;
        rd = pio_pending ? {junk[31:4], sw} : junk;
        pio_pending = m_read;
        s_address = sa; s_read = srd; s_write = swr; s_writedata = swd;
        m_readdata = rd;
        model_step(sa, srd, swr, swd, rd);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("m_read", 32'(m_read), 32'(m_phase == 1));
        check("m_address", 32'(m_address), 32'd0);
        check("s_readdata", s_readdata, m_rdata);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle();                                   cycle(2'd0, 1'b0, 1'b0, 32'd0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d); cycle(a, 1'b0, 1'b1, d);  endtask
    task automatic rdr(input logic [1:0] a);                 cycle(a, 1'b1, 1'b0, 32'd0); endtask

    task automatic do_reset();
        s_read = 0; s_write = 0; s_address = '0; s_writedata = '0;
        reset_n = 1'b0;
        #1;
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_m_address", 32'(m_address), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_s_readdata", s_readdata, 32'd0);
        model_reset();
        pio_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // True when the update now in progress completes a debounce transition.
    function automatic bit would_flip();
        int k;
        if (m_phase != 3) return 0;
        if (hist.size() < int'(DEB) - 1) return 0;
        k = hist.size() - int'(DEB) + 1;
        for (int i = k; i < hist.size(); i++) if (hist[i] != m_sample) return 0;
        return m_sample != m_deb;
    endfunction

    initial begin
        int pulses[$];
        int n, ups, hit, first_wait;
        logic [31:0] d;
        int unsigned op;

        @(negedge clk);
        do_reset();

        // Register defaults after reset.
        rdr(2'd0); check("rst_reg0", s_readdata, 32'd0);
        rdr(2'd1); check("rst_ctrl", s_readdata, 32'd0);
        rdr(2'd2); check("rst_period", s_readdata, 32'd1000);
        rdr(2'd3); check("rst_edge", s_readdata, 32'd0);
        for (int i = 0; i < 20; i++) idle();

        // Poll cadence with period 10.
        do_reset();
        sw = 4'h3;
        wr(2'd2, 32'd10);
        wr(2'd1, 32'd1);
        first_wait = -1;
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (m_read) begin
                pulses.push_back(i);
                if (first_wait < 0) first_wait = i;
            end
        end
        check("first_poll_wait", 32'(first_wait), 32'd10);
        check("poll_count", 32'(pulses.size()), 32'd7);
        for (int i = 1; i < pulses.size(); i++)
            check("poll_interval", 32'(pulses[i] - pulses[i-1]), 32'd13);

        // 0x0 -> 0x5 held, interrupt enabled.
        do_reset();
        sw = 4'h5;
        wr(2'd2, 32'd2);
        wr(2'd1, 32'd3);
        for (int i = 0; i < 40; i++) rdr(2'd0);
        check("deb_0x5", s_readdata, 32'h5);
        rdr(2'd3); check("edge_0x5", s_readdata, 32'h5);
        check("irq_0x5", 32'(irq), 32'd1);

        // Toggling input never settles.
        do_reset();
        sw = 4'h1;
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd3);
        for (int i = 0; i < 80; i++) begin
            if (m_phase == 3) sw = sw ^ 4'h1;
            rdr(2'(i % 2 == 0 ? 0 : 3));
        end
        rdr(2'd0); check("toggle_deb", s_readdata, 32'd0);
        rdr(2'd3); check("toggle_edge", s_readdata, 32'd0);
        check("toggle_irq", 32'(irq), 32'd0);

        // Clear of bit 0 coinciding with a new edge on bit 0.
        do_reset();
        sw = 4'h1;
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd3);
        for (int i = 0; i < 40; i++) idle();
        check("w1c_pre_irq", 32'(irq), 32'd1);
        sw = 4'h0;
        hit = 0;
        for (int i = 0; i < 80; i++) begin
            if (would_flip()) begin wr(2'd3, 32'd1); hit++; end
            else idle();
        end
        check("w1c_collision_hit", 32'(hit), 32'd1);
        rdr(2'd3); check("w1c_edge", s_readdata, 32'd1);
        check("w1c_irq", 32'(irq), 32'd1);

        // Enable cleared during the READ cycle: the sequence still finishes.
        do_reset();
        sw = 4'hA;
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd1);
        ups = 0;
        for (int i = 0; i < 200 && ups < 3; i++) begin
            idle();
            if (m_phase == 3) ups++;
        end
        for (int i = 0; i < 50 && m_phase != 1; i++) idle();
        check("dis_at_read", 32'(m_read), 32'd1);
        wr(2'd1, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (m_read) n++;
        end
        check("dis_no_more_reads", 32'(n), 32'd0);
        rdr(2'd0); check("dis_final_sample", s_readdata, 32'hA);

        // Reset asserted during CAPTURE.
        do_reset();
        sw = 4'h3;
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd3);
        for (int i = 0; i < 40; i++) rdr(2'd0);
        for (int i = 0; i < 50 && m_phase != 2; i++) rdr(2'd0);
        check("mid_pre_rdata", s_readdata, 32'h3);
        check("mid_pre_irq", 32'(irq), 32'd1);
        do_reset();
        rdr(2'd2); check("mid_period", s_readdata, 32'd1000);
        rdr(2'd1); check("mid_ctrl", s_readdata, 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin idle(); if (m_read) n++; end
        check("mid_no_reads", 32'(n), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        wr(2'd2, 32'd2);
        wr(2'd1, 32'd3);
        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 19);
            if ($urandom_range(0, 39) == 0) sw = 4'($urandom);
            d = $urandom;
            case (op)
                0, 1, 2, 3: rdr(2'($urandom));
                4: begin d[0] = ($urandom_range(0, 4) != 0); wr(2'd1, d); end
                5: begin d[15:0] = 16'($urandom_range(0, 6)); wr(2'd2, d); end
                6: wr(2'd3, d);
                7: wr(2'd0, d);
                8: cycle(2'($urandom), 1'b1, 1'b1, d);
                default: idle();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
